// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector benches.
// Holds the canonical 101111 pattern, the FSM state encoding and sizing helpers.
package seq_pattern_tx_pkg;

    localparam int PAT_W_DEF = 6;

    // Single source of truth for the pattern the detectors look for.
    localparam logic [PAT_W_DEF-1:0] SEQ_101111  = 6'b101111;
    localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = SEQ_101111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_e;

    // A zero-cycle gap still needs a one-bit counter so the port widths stay legal.
    function automatic int gap_cnt_w(input int gap_cyc);
        return (gap_cyc > 0) ? $clog2(gap_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-load, MSB-first shift register; reloaded at the start of every frame.
// Load has priority over shift; zeros are shifted in at the LSB.
module seq_piso_shreg
    import seq_pattern_tx_pkg::*;
#(
    parameter int              PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh,
    input  logic [PAT_W-1:0] din,
    output logic             sout
);

    logic [PAT_W-1:0] q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= PATTERN;
        end else if (ld) begin
            q <= din;
        end else if (sh) begin
            q <= {q[PAT_W-2:0], 1'b0};
        end
    end

    assign sout = q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a stored pattern MSB-first for a programmable
// number of frames, with an optional idle gap between frames. All outputs registered.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int              PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
    parameter int              CNT_W   = 4,
    parameter int              GAP_CYC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    input  logic             abort,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam int GAP_W = gap_cnt_w(GAP_CYC);

    tx_state_e        state, state_n;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] ld_val;
    logic [CNT_W-1:0] reps_q;
    logic [CNT_W-1:0] fs_inc;
    logic [BIT_W-1:0] bit_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             sh_ld, sh_en, sh_out;
    logic             frame_end, last_frame;

    assign fs_inc     = frames_sent + CNT_W'(1);
    assign frame_end  = (bit_idx == '0);
    assign last_frame = (fs_inc == reps_q);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n = state;
        sh_ld   = 1'b0;
        sh_en   = 1'b0;
        ld_val  = pat_q;
        case (state)
            ST_IDLE: begin
                // A load in the same cycle as start must feed the first frame.
                ld_val = pat_load ? pat_in : pat_q;
                if (start) begin
                    if (reps != '0) begin
                        state_n = ST_SHIFT;
                        sh_ld   = 1'b1;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else begin
                    sh_en = 1'b1;
                    if (frame_end) begin
                        if (last_frame) begin
                            state_n = ST_DONE;
                        end else if (GAP_CYC == 0) begin
                            sh_ld = 1'b1;
                        end else begin
                            state_n = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (gap_cnt == '0) begin
                    state_n = ST_SHIFT;
                    sh_ld   = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    seq_piso_shreg #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_shreg (
        .clk  (clk),
        .rst  (rst),
        .ld   (sh_ld),
        .sh   (sh_en),
        .din  (ld_val),
        .sout (sh_out)
    );

    // Outputs reflect the state held before each edge, so they trail the FSM by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pat_q       <= PATTERN;
            reps_q      <= '0;
            frames_sent <= '0;
            bit_idx     <= BIT_W'(PAT_W - 1);
            gap_cnt     <= '0;
            x           <= 1'b0;
            x_valid     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state   <= state_n;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pat_load) begin
                        pat_q <= pat_in;
                    end
                    if (start) begin
                        reps_q      <= reps;
                        frames_sent <= '0;
                        bit_idx     <= BIT_W'(PAT_W - 1);
                    end
                end
                ST_SHIFT: begin
                    if (!abort) begin
                        x       <= sh_out;
                        x_valid <= 1'b1;
                        busy    <= 1'b1;
                        if (frame_end) begin
                            frames_sent <= fs_inc;
                            bit_idx     <= BIT_W'(PAT_W - 1);
                            gap_cnt     <= GAP_W'(GAP_CYC - 1);
                        end else begin
                            bit_idx <= bit_idx - BIT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (!abort) begin
                        busy    <= 1'b1;
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    done <= 1'b1;
                end
            endcase
        end
    end

endmodule
